// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// The build macro LSU_MISALIGN_TRAP_EN removes the second-beat states: accesses
// crossing a word boundary then complete with an error instead of being split.
package lsu_pkg;

    // Operation code: {we, funct3}. Loads and stores share funct3 encodings,
    // so the write bit keeps every member distinct.
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } lsu_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHK   = 3'd1,
        S_REQ1  = 3'd2,
        S_WAIT1 = 3'd3,
`ifndef LSU_MISALIGN_TRAP_EN
        S_REQ2  = 3'd4,
        S_WAIT2 = 3'd5,
`endif
        S_RESP  = 3'd6
    } lsu_state_e;

    // True when {we, funct3} names one of the supported operations.
    function automatic logic op_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        case ({we, funct3})
            LB, LH, LW, LBU, LHU, SB, SH, SW: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Access size in bytes (1, 2 or 4) from funct3[1:0].
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        logic [2:0] sz;
        case (funct3[1:0])
            2'b00:   sz = 3'd1;
            2'b01:   sz = 3'd2;
            default: sz = 3'd4;
        endcase
        return sz;
    endfunction

    // Byte enables for both beats: [3:0] first word, [7:4] following word.
    function automatic logic [7:0] be_mask(input logic [2:0] size, input logic [1:0] off);
        logic [7:0] m;
        case (size)
            3'd1:    m = 8'h01;
            3'd2:    m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed bytes out of a {hi, lo} word pair
// and sign- or zero-extends them according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] shifted_s;

    assign shifted_s = 32'({hi, lo} >> {off, 3'b000});

    // Keep the low size bytes and extend them (funct3[2] selects unsigned).
    always_comb begin
        rdata = 32'd0;
        case (funct3)
            3'b000:  rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b100:  rdata = {24'd0, shifted_s[7:0]};
            3'b101:  rdata = {16'd0, shifted_s[15:0]};
            default: rdata = shifted_s;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: accepts one request from execute, checks it, drives
// one or two word-addressed bus beats with byte enables, and returns the
// extended load data with a one-cycle completion pulse.
// Build option LSU_MISALIGN_TRAP_EN: word-crossing accesses report an error
// instead of being split into two beats.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_r;
    lsu_state_e        state_s;

    logic              we_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
`ifndef LSU_MISALIGN_TRAP_EN
    logic [31:0]       beat1_r;
`endif

    logic [2:0]        size_s;
    logic [1:0]        off_s;
    logic [7:0]        be_all_s;
    logic [63:0]       wdata_all_s;
    logic [ADDR_W-1:0] base_addr_s;
    logic [ADDR_W:0]   last_byte_s;
    logic              oor_s;
    logic              cross_s;
    logic              op_ok_s;
    logic              legal_s;

    logic [31:0]       align_lo_s;
    logic [31:0]       align_hi_s;
    logic [31:0]       align_rdata_s;

    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_err_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [3:0]        mem_be_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_be    = mem_be_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

    // Decode the latched request: lanes, shifted data, range and legality.
    always_comb begin
        size_s      = size_of(funct3_r);
        off_s       = addr_r[1:0];
        be_all_s    = be_mask(size_s, off_s);
        wdata_all_s = {32'd0, wdata_r} << {off_s, 3'b000};
        base_addr_s = {addr_r[ADDR_W-1:2], 2'b00};
        last_byte_s = {1'b0, addr_r} + {{(ADDR_W-2){1'b0}}, size_s} - {{ADDR_W{1'b0}}, 1'b1};
        oor_s       = (last_byte_s >= (ADDR_W+1)'(MEM_BYTES));
        cross_s     = (({1'b0, off_s} + size_s) > 3'd4);
        op_ok_s     = op_legal(we_r, funct3_r);
`ifdef LSU_MISALIGN_TRAP_EN
        legal_s     = op_ok_s & ~oor_s & ~cross_s;
`else
        legal_s     = op_ok_s & ~oor_s;
`endif
    end

    // Word pair for load assembly: the final beat's bus data is used directly
    // so the response can be registered on the same edge that ends the wait.
    always_comb begin
        align_lo_s = mem_rdata;
        align_hi_s = 32'd0;
`ifndef LSU_MISALIGN_TRAP_EN
        if (state_r == S_WAIT2) begin
            align_lo_s = beat1_r;
            align_hi_s = mem_rdata;
        end else begin
            align_lo_s = mem_rdata;
            align_hi_s = 32'd0;
        end
`endif
    end

    lsu_load_align u_load_align (
        .lo     (align_lo_s),
        .hi     (align_hi_s),
        .off    (off_s),
        .funct3 (funct3_r),
        .rdata  (align_rdata_s)
    );

    // Next-state logic for the access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) state_s = S_CHK;
                else           state_s = S_IDLE;
            end
            S_CHK: begin
                if (legal_s) state_s = S_REQ1;
                else         state_s = S_RESP;
            end
            S_REQ1: begin
                if (mem_gnt) state_s = S_WAIT1;
                else         state_s = S_REQ1;
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_s = S_RESP;
`else
                    if (cross_s) state_s = S_REQ2;
                    else         state_s = S_RESP;
`endif
                end else begin
                    state_s = S_WAIT1;
                end
            end
`ifndef LSU_MISALIGN_TRAP_EN
            S_REQ2: begin
                if (mem_gnt) state_s = S_WAIT2;
                else         state_s = S_REQ2;
            end
            S_WAIT2: begin
                if (mem_rvalid) state_s = S_RESP;
                else            state_s = S_WAIT2;
            end
`endif
            S_RESP:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_s;
    end

    // Request fields latched on accept; first-beat read data held for splits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r     <= 1'b0;
            funct3_r <= 3'd0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= 32'd0;
`ifndef LSU_MISALIGN_TRAP_EN
            beat1_r  <= 32'd0;
`endif
        end else if ((state_r == S_IDLE) && req_valid) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
`ifndef LSU_MISALIGN_TRAP_EN
        end else if ((state_r == S_WAIT1) && mem_rvalid) begin
            beat1_r  <= mem_rdata;
`endif
        end
    end

    // Registered outputs, decoded from the state being entered so they line
    // up with the state register; the bus fields stay constant while waiting
    // for a grant because the latched request does not change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'd0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
        end else begin
            req_ready_r <= (state_s == S_IDLE);
            rsp_valid_r <= (state_s == S_RESP);
            rsp_err_r   <= (state_s == S_RESP) && (state_r == S_CHK);
            if ((state_s == S_RESP) && (state_r != S_CHK) && !we_r) begin
                rsp_rdata_r <= align_rdata_s;
            end else begin
                rsp_rdata_r <= 32'd0;
            end
            case (state_s)
                S_REQ1: begin
                    mem_req_r   <= 1'b1;
                    mem_we_r    <= we_r;
                    mem_be_r    <= be_all_s[3:0];
                    mem_addr_r  <= base_addr_s;
                    mem_wdata_r <= we_r ? wdata_all_s[31:0] : 32'd0;
                end
`ifndef LSU_MISALIGN_TRAP_EN
                S_REQ2: begin
                    mem_req_r   <= 1'b1;
                    mem_we_r    <= we_r;
                    mem_be_r    <= be_all_s[7:4];
                    mem_addr_r  <= base_addr_s + {{(ADDR_W-3){1'b0}}, 3'd4};
                    mem_wdata_r <= we_r ? wdata_all_s[63:32] : 32'd0;
                end
`endif
                default: begin
                    mem_req_r   <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_be_r    <= 4'd0;
                    mem_addr_r  <= {ADDR_W{1'b0}};
                    mem_wdata_r <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus randomized
// loads/stores against a byte-array reference memory. The bus side is a
// byte-addressed memory with programmable grant and rvalid delays.
module tb_lsu_mem_ctrl;

    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 128;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  bus_mem [0:MEM_BYTES-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] beat_addr  [0:1];
    logic [3:0]  beat_be    [0:1];
    logic [31:0] beat_wdata [0:1];
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete access: reference expectation, stimulus, bus responder, checks.
    task automatic run_op(input logic we, input logic [2:0] f3, input int addr,
                          input logic [31:0] wdata, input int gd, input int rd);
        int           size, off, nbeats, exp_beats, exp_lat, cyc, gcnt, rcnt, idx;
        bit           legal, err_exp, done, holding, pend_rv;
        logic [31:0]  exp_rdata, rv_data, h_addr, h_wd;
        logic [3:0]   h_be, oor_lanes;
        logic         h_we;
        logic [127:0] touched, exp_touched;
        logic [63:0]  v;

        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        off  = addr % 4;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        err_exp = !legal || (addr + size > MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
        if (off + size > 4) err_exp = 1'b1;
`endif
        exp_beats   = err_exp ? 0 : ((off + size > 4) ? 2 : 1);
        exp_lat     = err_exp ? 2 : 2 + exp_beats * (2 + gd + rd);
        exp_touched = 128'd0;
        exp_rdata   = 32'd0;
        if (!err_exp) begin
            for (int i = 0; i < size; i++) exp_touched[addr + i] = 1'b1;
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[addr + i];
                if (!f3[2] && v[8*size - 1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
                exp_rdata = v[31:0];
            end
        end

        @(negedge clk);
        check_eq("ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = 32'(addr);
        req_wdata  = wdata;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        cyc = 1; nbeats = 0; done = 0; holding = 0; pend_rv = 0;
        gcnt = 0; rcnt = 0; touched = 128'd0; rv_data = 32'd0;
        h_addr = 32'd0; h_wd = 32'd0; h_be = 4'd0; h_we = 1'b0;
        while (!done && cyc <= 400) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (rsp_valid) begin
                done       = 1;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                last_lat   = cyc;
            end else begin
                if (pend_rv) begin
                    if (rcnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rv_data;
                        pend_rv    = 0;
                    end else begin
                        rcnt--;
                    end
                end
                if (mem_req) begin
                    if (!holding) begin
                        holding = 1;
                        h_addr = mem_addr; h_be = mem_be; h_we = mem_we; h_wd = mem_wdata;
                        gcnt = gd;
                        if (nbeats < 2) begin
                            beat_addr[nbeats]  = mem_addr;
                            beat_be[nbeats]    = mem_be;
                            beat_wdata[nbeats] = mem_wdata;
                        end
                        nbeats++;
                        check_eq("beat_align", 32'(mem_addr[1:0]), 32'd0);
                        check_eq("beat_we", 32'(mem_we), 32'(we));
                    end else begin
                        check_eq("hold_addr", mem_addr, h_addr);
                        check_eq("hold_be", 32'(mem_be), 32'(h_be));
                        check_eq("hold_wdata", mem_wdata, h_wd);
                        check_eq("hold_we", 32'(mem_we), 32'(h_we));
                    end
                    if (gcnt == 0) begin
                        mem_gnt = 1'b1;
                        holding = 0;
                        pend_rv = 1;
                        rcnt    = rd;
                        oor_lanes = 4'd0;
                        for (int i = 0; i < 4; i++) begin
                            idx = int'(mem_addr) + i;
                            if (idx >= 0 && idx < MEM_BYTES) begin
                                rv_data[8*i +: 8] = bus_mem[idx];
                                if (mem_be[i]) begin
                                    touched[idx] = 1'b1;
                                    if (mem_we) bus_mem[idx] = mem_wdata[8*i +: 8];
                                end
                            end else begin
                                rv_data[8*i +: 8] = 8'h00;
                                if (mem_be[i]) oor_lanes[i] = 1'b1;
                            end
                        end
                        check_eq("beat_range", 32'(oor_lanes), 32'd0);
                    end else begin
                        gcnt--;
                    end
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check_eq("rsp_timeout", 32'(done), 32'd1);
        if (done) begin
            check_eq("rsp_err", 32'(last_err), 32'(err_exp));
            check_eq("rsp_rdata", last_rdata, exp_rdata);
            check_eq("latency", 32'(last_lat), 32'(exp_lat));
            check_eq("beats", 32'(nbeats), 32'(exp_beats));
            for (int k = 0; k < 4; k++) check_eq("touched", touched[32*k +: 32], exp_touched[32*k +: 32]);
            @(negedge clk);
            check_eq("rsp_pulse", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [2:0]  legal_f3 [0:4];
        int          addr;

        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_be", 32'(mem_be), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;

        // lw 0x10 with a zero-wait bus
        run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
        run_op(1'b0, 3'b010, 32'h10, 32'd0, 0, 0);
        check_eq("t1_addr", beat_addr[0], 32'h10);
        check_eq("t1_be", 32'(beat_be[0]), 32'hF);
        check_eq("t1_rdata", last_rdata, 32'hDEADBEEF);
        check_eq("t1_lat", 32'(last_lat), 32'd4);

        // byte/half extension
        run_op(1'b1, 3'b010, 32'h10, 32'h80FFFFFF, 0, 0);
        run_op(1'b0, 3'b000, 32'h13, 32'd0, 0, 1);
        check_eq("t2_lb", last_rdata, 32'hFFFFFF80);
        run_op(1'b0, 3'b100, 32'h13, 32'd0, 1, 0);
        check_eq("t2_lbu", last_rdata, 32'h00000080);
        run_op(1'b0, 3'b001, 32'h12, 32'd0, 0, 0);
        check_eq("t2_lh", last_rdata, 32'hFFFF80FF);

        // sh 0x06
        run_op(1'b1, 3'b001, 32'h06, 32'h1234ABCD, 0, 0);
        check_eq("t3_addr", beat_addr[0], 32'h04);
        check_eq("t3_be", 32'(beat_be[0]), 32'hC);
        check_eq("t3_wdata", beat_wdata[0], 32'hABCD0000);
        check_eq("t3_err", 32'(last_err), 32'd0);

        // sw 0x0E crossing a word boundary
        run_op(1'b1, 3'b010, 32'h0E, 32'hAABBCCDD, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("t4_err", 32'(last_err), 32'd1);
`else
        check_eq("t4_b1_addr", beat_addr[0], 32'h0C);
        check_eq("t4_b1_be", 32'(beat_be[0]), 32'hC);
        check_eq("t4_b1_wdata", beat_wdata[0], 32'hCCDD0000);
        check_eq("t4_b2_addr", beat_addr[1], 32'h10);
        check_eq("t4_b2_be", 32'(beat_be[1]), 32'h3);
        check_eq("t4_b2_wdata", beat_wdata[1], 32'h0000AABB);
`endif

        // range and funct3 legality
        run_op(1'b0, 3'b010, 32'h7C, 32'd0, 0, 0);
        check_eq("t5_lw7c_err", 32'(last_err), 32'd0);
        run_op(1'b0, 3'b010, 32'h80, 32'd0, 0, 0);
        check_eq("t5_lw80_err", 32'(last_err), 32'd1);
        run_op(1'b1, 3'b100, 32'h20, 32'h11111111, 0, 0);
        check_eq("t5_st100_err", 32'(last_err), 32'd1);
        run_op(1'b0, 3'b011, 32'h20, 32'd0, 0, 0);
        check_eq("t5_ld011_err", 32'(last_err), 32'd1);

        // grant held off for 5 cycles (stability is checked inside run_op)
        run_op(1'b1, 3'b000, 32'h31, 32'h000000A5, 5, 2);
        run_op(1'b0, 3'b101, 32'h32, 32'd0, 5, 0);

        // reset while waiting for rvalid, then a stray rvalid
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("t6_req_before_rst", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("t6_rst_mem_addr", mem_addr, 32'd0);
        check_eq("t6_rst_mem_be", 32'(mem_be), 32'd0);
        check_eq("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("t6_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t6_stray_rsp", 32'(rsp_valid), 32'd0);
            check_eq("t6_stray_req", 32'(mem_req), 32'd0);
            @(negedge clk);
        end
        run_op(1'b0, 3'b010, 32'h20, 32'd0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, 4)];
            if (we && f3[2] && $urandom_range(0, 1) == 1) f3 = {1'b0, f3[1:0]};
            addr = $urandom_range(0, MEM_BYTES + 7);
            run_op(we, f3, addr, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        for (int i = 0; i < MEM_BYTES; i++) check_eq("mem_byte", 32'(bus_mem[i]), 32'(ref_mem[i]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
